// File: rtl/floor_request_latch.sv
// Floor-call button front end: synchronises, debounces and edge-detects raw buttons,
// latches one request per floor and derives pending/direction flags.
module floor_request_latch #(
    parameter int unsigned NUM_FLOORS      = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic [7:0] btn_raw,
    input  logic       clr_valid,
    input  logic [3:0] clr_floor,
    input  logic [3:0] cur_floor,
    output logic [7:0] floor_btn,
    output logic       req_pending,
    output logic       has_above,
    output logic       has_below,
    output logic       new_req,
    output logic [3:0] new_req_floor
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_FLOORS-1:0] sync_a, sync_b;
    logic [NUM_FLOORS-1:0] deb, deb_q, press;
    logic [CNT_W-1:0]      cnt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] btn_next, btn_q, rise;
    logic                  above_c, below_c;
    logic [3:0]            rise_lo;
    logic                  rise_found;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int unsigned i = 0; i < NUM_FLOORS; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
                if (sync_b[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync_b[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            press <= '0;
        end else begin
            deb_q <= deb;
            press <= deb & ~deb_q;
        end
    end

    // Service clear takes priority over a same-cycle press on the same floor.
    always_comb begin
        btn_next = floor_btn;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (clr_valid && (clr_floor == 4'(i)))
                btn_next[i] = 1'b0;
            else if (press[i])
                btn_next[i] = 1'b1;
        end
    end

    always_comb begin
        rise       = floor_btn & ~btn_q;
        rise_lo    = '0;
        rise_found = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (rise[i] && !rise_found) begin
                rise_lo    = 4'(i);
                rise_found = 1'b1;
            end
        end
    end

    always_comb begin
        above_c = 1'b0;
        below_c = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (floor_btn[i] && (i > 32'(cur_floor)))
                above_c = 1'b1;
            if (floor_btn[i] && (i < 32'(cur_floor)))
                below_c = 1'b1;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            floor_btn     <= '0;
            btn_q         <= '0;
            req_pending   <= 1'b0;
            has_above     <= 1'b0;
            has_below     <= 1'b0;
            new_req       <= 1'b0;
            new_req_floor <= '0;
        end else begin
            floor_btn   <= btn_next;
            btn_q       <= floor_btn;
            req_pending <= |floor_btn;
            has_above   <= above_c;
            has_below   <= below_c;
            new_req     <= rise_found;
            if (rise_found)
                new_req_floor <= rise_lo;
        end
    end

endmodule

// File: tb/tb_floor_request_latch.sv
// Self-checking bench for floor_request_latch with a short debounce window, directed
// scenarios plus randomized traffic compared against a sample-history reference model.
module tb_floor_request_latch;

    localparam int D = 4;

    logic       ck;
    logic       rst_n;
    logic [7:0] btn_raw;
    logic       clr_valid;
    logic [3:0] clr_floor;
    logic [3:0] cur_floor;
    logic [7:0] floor_btn;
    logic       req_pending;
    logic       has_above;
    logic       has_below;
    logic       new_req;
    logic [3:0] new_req_floor;

    int tests_run = 0;
    int tests_failed = 0;

    floor_request_latch #(
        .NUM_FLOORS(8),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .ck(ck),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .clr_valid(clr_valid),
        .clr_floor(clr_floor),
        .cur_floor(cur_floor),
        .floor_btn(floor_btn),
        .req_pending(req_pending),
        .has_above(has_above),
        .has_below(has_below),
        .new_req(new_req),
        .new_req_floor(new_req_floor)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Reference model: raw sample history per edge; a level flips once the last D
    // synchronised samples all disagree with it; a rising flip sets the request two edges later.
    logic [7:0] m_hist [0:D+1];
    logic [7:0] m_deb, m_pipe0, m_pipe1, m_floor, m_last_rise;
    logic       m_new_req, m_pend, m_above, m_below;
    logic [3:0] m_nrf;

    task automatic model_reset;
        for (int j = 0; j <= D + 1; j++) m_hist[j] = 8'h00;
        m_deb = 0; m_pipe0 = 0; m_pipe1 = 0; m_floor = 0; m_last_rise = 0;
        m_new_req = 0; m_pend = 0; m_above = 0; m_below = 0; m_nrf = 0;
    endtask

    task automatic model_step;
        logic [7:0] rise_now, nxt, clrm;
        logic       stable;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int j = D + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = btn_raw;
            rise_now = 8'h00;
            for (int i = 0; i < 8; i++) begin
                stable = 1'b1;
                for (int j = 2; j <= D + 1; j++)
                    if (m_hist[j][i] == m_deb[i]) stable = 1'b0;
                if (stable) begin
                    m_deb[i] = ~m_deb[i];
                    if (m_deb[i]) rise_now[i] = 1'b1;
                end
            end
            m_new_req = |m_last_rise;
            if (m_new_req)
                for (int i = 7; i >= 0; i--)
                    if (m_last_rise[i]) m_nrf = 4'(i);
            m_pend  = |m_floor;
            m_above = 1'b0;
            m_below = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (m_floor[i] && i > int'(cur_floor)) m_above = 1'b1;
                if (m_floor[i] && i < int'(cur_floor)) m_below = 1'b1;
            end
            clrm = (clr_valid && clr_floor < 4'd8) ? (8'h01 << clr_floor) : 8'h00;
            nxt = (m_floor | m_pipe1) & ~clrm;
            m_pipe1 = m_pipe0;
            m_pipe0 = rise_now;
            m_last_rise = nxt & ~m_floor;
            m_floor = nxt;
        end
    endtask

    // Advance one clock; inputs were set after the previous falling edge.
    task automatic tick;
        model_step();
        @(posedge ck);
        @(negedge ck);
    endtask

    task automatic clear_pulse(input logic [3:0] fl);
        clr_valid = 1'b1;
        clr_floor = fl;
        tick();
        clr_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] outs;
        outs = {floor_btn, req_pending, has_above, has_below, new_req, new_req_floor};
        tests_run++;
        if (outs !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_initial: outputs=%h expected=0000", outs);
        end
        btn_raw = 8'hFF;
        for (int k = 0; k < 10; k++) tick();
        tests_run++;
        if (floor_btn !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_preload: floor_btn=%h expected=ff", floor_btn);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        outs = {floor_btn, req_pending, has_above, has_below, new_req, new_req_floor};
        tests_run++;
        if (outs !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_async: outputs=%h expected=0000", outs);
        end
        @(negedge ck);
        tick();
        tick();
        rst_n = 1'b1;
        btn_raw = 8'h00;
        for (int k = 0; k < 12; k++) begin
            tick();
            tests_run++;
            if (floor_btn !== 8'h00 || new_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_idle k=%0d: floor_btn=%h new_req=%b expected 00/0", k, floor_btn, new_req);
            end
        end
    endtask

    task automatic test_clean_press;
        logic [7:0] exp_fb;
        btn_raw = 8'h08;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_fb = (k >= 7) ? 8'h08 : 8'h00;
            tests_run++;
            if (floor_btn !== exp_fb || new_req !== (k == 8) || req_pending !== (k >= 8)) begin
                tests_failed++;
                $display("FAIL clean_press k=%0d: fb=%h nr=%b pend=%b expected fb=%h nr=%b pend=%b",
                         k, floor_btn, new_req, req_pending, exp_fb, (k == 8), (k >= 8));
            end
            if (k == 8) begin
                tests_run++;
                if (new_req_floor !== 4'd3) begin
                    tests_failed++;
                    $display("FAIL clean_press_floor: new_req_floor=%0d expected=3", new_req_floor);
                end
            end
        end
        btn_raw = 8'h00;
        for (int k = 0; k < 8; k++) tick();
        tests_run++;
        if (floor_btn !== 8'h08) begin
            tests_failed++;
            $display("FAIL release_ignored: floor_btn=%h expected=08", floor_btn);
        end
    endtask

    task automatic test_bounce;
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int pulses;
        for (int k = 0; k < 13; k++) begin
            btn_raw = (k < 5 && pat[k]) ? 8'h20 : 8'h00;
            tick();
            tests_run++;
            if (floor_btn !== 8'h08 || new_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce k=%0d: fb=%h nr=%b expected fb=08 nr=0", k, floor_btn, new_req);
            end
        end
        btn_raw = 8'h20;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (new_req) pulses++;
        end
        tests_run++;
        if (pulses != 1 || floor_btn !== 8'h28 || new_req_floor !== 4'd5) begin
            tests_failed++;
            $display("FAIL bounce_hold: pulses=%0d fb=%h nrf=%0d expected 1/28/5", pulses, floor_btn, new_req_floor);
        end
        btn_raw = 8'h00;
        for (int k = 0; k < 6; k++) tick();
    endtask

    task automatic test_service_clear;
        clear_pulse(4'd5);
        tests_run++;
        if (floor_btn !== 8'h08) begin
            tests_failed++;
            $display("FAIL clear_5: floor_btn=%h expected=08", floor_btn);
        end
        clear_pulse(4'd9);
        tests_run++;
        if (floor_btn !== 8'h08) begin
            tests_failed++;
            $display("FAIL clear_out_of_range: floor_btn=%h expected=08", floor_btn);
        end
        clear_pulse(4'd0);
        tick();
        tests_run++;
        if (floor_btn !== 8'h08 || req_pending !== 1'b1 || new_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_idle_bit: fb=%h pend=%b nr=%b expected 08/1/0", floor_btn, req_pending, new_req);
        end
    endtask

    task automatic test_collision;
        btn_raw = 8'h04;
        for (int k = 0; k < 7; k++) tick();
        clear_pulse(4'd2);
        tests_run++;
        if (floor_btn !== 8'h08) begin
            tests_failed++;
            $display("FAIL collision_same: floor_btn=%h expected=08", floor_btn);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (new_req !== 1'b0 || floor_btn !== 8'h08) begin
                tests_failed++;
                $display("FAIL collision_no_req k=%0d: nr=%b fb=%h expected 0/08", k, new_req, floor_btn);
            end
        end
        btn_raw = 8'h00;
        for (int k = 0; k < 8; k++) tick();
        btn_raw = 8'h40;
        for (int k = 0; k < 10; k++) tick();
        btn_raw = 8'h00;
        for (int k = 0; k < 8; k++) tick();
        btn_raw = 8'h02;
        for (int k = 0; k < 7; k++) tick();
        clear_pulse(4'd6);
        tests_run++;
        if (floor_btn !== 8'h0A) begin
            tests_failed++;
            $display("FAIL collision_diff: floor_btn=%h expected=0a", floor_btn);
        end
        tick();
        tests_run++;
        if (new_req !== 1'b1 || new_req_floor !== 4'd1) begin
            tests_failed++;
            $display("FAIL collision_diff_req: nr=%b nrf=%0d expected 1/1", new_req, new_req_floor);
        end
        btn_raw = 8'h00;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_direction_flags;
        logic [3:0] seen_nrf;
        clear_pulse(4'd3);
        clear_pulse(4'd1);
        btn_raw = 8'h81;
        seen_nrf = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (new_req) seen_nrf = new_req_floor;
        end
        btn_raw = 8'h00;
        for (int k = 0; k < 6; k++) tick();
        tests_run++;
        if (floor_btn !== 8'h81 || seen_nrf !== 4'd0) begin
            tests_failed++;
            $display("FAIL dir_setup: fb=%h nrf=%0d expected 81/0", floor_btn, seen_nrf);
        end
        cur_floor = 4'd3;
        tick();
        tests_run++;
        if (has_above !== 1'b1 || has_below !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_both: above=%b below=%b expected 1/1", has_above, has_below);
        end
        clear_pulse(4'd7);
        tests_run++;
        if (floor_btn !== 8'h01 || has_above !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_lag: fb=%h above=%b expected 01/1", floor_btn, has_above);
        end
        tick();
        tests_run++;
        if (has_above !== 1'b0 || has_below !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_after_clear: above=%b below=%b expected 0/1", has_above, has_below);
        end
        cur_floor = 4'd0;
        tick();
        tests_run++;
        if (has_above !== 1'b0 || has_below !== 1'b0 || req_pending !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_at_floor: above=%b below=%b pend=%b expected 0/0/1", has_above, has_below, req_pending);
        end
        cur_floor = 4'd12;
        tick();
        tests_run++;
        if (has_above !== 1'b0 || has_below !== 1'b1) begin
            tests_failed++;
            $display("FAIL dir_out_of_range: above=%b below=%b expected 0/1", has_above, has_below);
        end
    endtask

    task automatic test_random;
        logic [15:0] outs, exp;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) btn_raw[i] = ~btn_raw[i];
            clr_valid = ($urandom_range(0, 5) == 0);
            clr_floor = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) cur_floor = 4'($urandom_range(0, 10));
            rst_n = (c != 1500);
            tick();
            outs = {floor_btn, req_pending, has_above, has_below, new_req, new_req_floor};
            exp  = {m_floor, m_pend, m_above, m_below, m_new_req, m_nrf};
            tests_run++;
            if (outs !== exp) begin
                tests_failed++;
                $display("FAIL random c=%0d: {fb,pend,abv,blw,nr,nrf}=%h expected=%h", c, outs, exp);
            end
        end
        rst_n = 1'b1;
        clr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        btn_raw = 8'h00;
        clr_valid = 1'b0;
        clr_floor = 4'd0;
        cur_floor = 4'd0;
        model_reset();
        @(negedge ck);
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_service_clear();
        test_collision();
        test_direction_flags();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/floor_request_latch.md
Name: floor_request_latch

Overview:
- Input-side counterpart of the elevator display path. Takes raw floor-call push-buttons, then synchronises, debounces and edge-detects them.
- Holds one latched request bit per floor and produces the `floor_btn[7:0]` vector that the display shows on its LEDs.
- Clears a request when the controller reports service at that floor.
- Also provides registered above/below-pending flags for direction decisions.

Parameters:
- NUM_FLOORS, 8, number of floors and buttons; fixed at 8 for the `floor_btn` width.
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised samples required before the debounced level changes; minimum 2.
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- ck  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_raw  input  8  raw, asynchronous, bouncing floor buttons; bit i = floor i, active high.
- clr_valid  input  1  single-cycle pulse: the request at clr_floor has been served.
- clr_floor  input  4  floor being served; qualified by clr_valid.
- cur_floor  input  4  current elevator floor, used for the above/below flags.
- floor_btn  output  8  latched requests; bit i = 1 means floor i is pending.
- req_pending  output  1  OR of floor_btn.
- has_above  output  1  some request at a floor > cur_floor.
- has_below  output  1  some request at a floor < cur_floor.
- new_req  output  1  single-cycle pulse when any request bit newly sets.
- new_req_floor  output  4  lowest-index floor whose bit set on the new_req cycle.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0. Synchronisers, debounced levels and counters are 0. Reset releases synchronously to ck.
- Reset mid-operation discards all pending requests and any partial debounce.
- Synchronise: each btn_raw bit passes through a 2-flop synchroniser, giving sync[i].
- Debounce, per bit, with a counter cnt[i] and level deb[i]:
  - If sync[i] == deb[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments.
  - When sync[i] != deb[i] and cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync[i] and cnt[i] <= 0.
  - Any glitch back to deb[i] before that point restarts the count.
- Edge detect: press event p[i] = deb[i] rising (deb[i]=1, previous deb[i]=0). Release edges are ignored. Holding a button produces exactly one event.
- Request register, per bit, each cycle:
  - Clear when clr_valid=1 and clr_floor==i.
  - Otherwise set when p[i]=1.
  - Otherwise hold.
  - Clear wins over a same-cycle set on the same bit; that press is lost.
- A set and a clear on different bits in the same cycle both take effect.
- clr_floor >= NUM_FLOORS is ignored.
- Clearing a bit that is already 0 has no effect.
- Latency: a clean raw press first sampled high at edge N sets floor_btn[i] at edge N+2+DEBOUNCE_CYCLES+1.
- floor_btn (registered) updates on that same edge.
- new_req:
  - new_req=1 for exactly the cycle after any bit transitions 0->1.
  - new_req_floor is the lowest such index, latched on the same edge; it holds its value while new_req=0.
  - A press on a bit that is already set produces no new_req.
- req_pending, has_above, has_below: registered from the current floor_btn and cur_floor, so they lag floor_btn by one cycle.
  - has_above = OR of floor_btn[j] for j > cur_floor.
  - has_below = OR of floor_btn[j] for j < cur_floor.
  - A request at cur_floor itself contributes to neither flag.
  - cur_floor >= NUM_FLOORS: has_above=0, has_below=req_pending.
- Multiple buttons may be pressed simultaneously; each bit is independent.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert rst_n=0 mid-cycle with btn_raw=8'hFF -> all outputs 0 immediately. Release and hold btn_raw=8'h00 -> floor_btn stays 8'h00, new_req never pulses.
- Clean press: btn_raw[3] high from edge 10, held 20 cycles -> floor_btn=8'h08 at edge 17, new_req=1 at edge 18 only with new_req_floor=3, req_pending=1 at edge 18.
- Bounce: btn_raw[5] toggles 1,0,1,1,0 on consecutive cycles, then low -> floor_btn unchanged, no new_req. Then hold high for 6+ cycles -> bit 5 sets exactly once.
- Service clear: floor_btn=8'h28, pulse clr_valid with clr_floor=5 -> floor_btn=8'h08 next edge. Pulse clr_floor=9 -> no change.
- Collision: arrange the press set for bit 2 on the same edge as clr_valid with clr_floor=2 -> bit 2 remains 0, no new_req. Same-edge set of bit 1 with clear of bit 6 -> bit 1=1, bit 6=0.
- Direction flags: floor_btn=8'h81, cur_floor=3 -> has_above=1, has_below=1. Clear floor 7 -> has_above=0 one cycle after floor_btn updates. Set cur_floor=0 -> has_below=0 (the request is at the current floor).
